// File: rtl/vram_pkg.sv
// Shared VRAM geometry constants and the host-port read FSM state type.
package vram_pkg;
  localparam int VRAM_BANK_ADDRESS_WIDTH = 14;
  localparam int VRAM_WORD_WIDTH         = 16;
  localparam int VRAM_READ_LATENCY       = 1;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_READ_WAIT    = 2'd1,
    ST_READ_CAPTURE = 2'd2
  } read_state_t;
endpackage

// File: rtl/vram_write_fifo.sv
// Synchronous write-buffer FIFO with occupancy count; DEPTH must be a power of 2.
module vram_write_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 31
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_full;
  logic             w_push;
  logic             w_pop;

  assign w_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !w_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end
endmodule

// File: rtl/vram_host_port.sv
// CPU-side VRAM initiator: buffered word writes, blocking word reads, and
// bank access only in arbiter-granted slot cycles.
module vram_host_port
  import vram_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int ADDRESS_WIDTH = 15
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     host_valid,
  input  logic                     host_write,
  input  logic [ADDRESS_WIDTH-1:0] host_address,
  input  logic [15:0]              host_write_data,
  output logic                     host_ready,
  output logic [15:0]              host_read_data,
  output logic                     host_read_valid,
  input  logic                     slot_available,
  output logic [13:0]              vram_even_address,
  output logic [13:0]              vram_odd_address,
  output logic                     vram_even_write_en,
  output logic                     vram_odd_write_en,
  output logic [31:0]              vram_write_data,
  input  logic [31:0]              vram_read_data,
  output logic                     busy
);
  localparam int ENTRY_W = ADDRESS_WIDTH + VRAM_WORD_WIDTH;
  localparam int CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  read_state_t r_state;
  read_state_t w_state_next;

  logic                               r_host_ready;
  logic [ADDRESS_WIDTH-2:0]           r_rd_address;
  logic                               r_rd_bank;
  logic [15:0]                        r_host_read_data;
  logic                               r_host_read_valid;
  logic [VRAM_BANK_ADDRESS_WIDTH-1:0] r_last_address;
  logic [31:0]                        r_last_wdata;

  logic                               w_accept;
  logic                               w_push;
  logic                               w_read_accept;
  logic                               w_pop;
  logic                               w_fifo_empty;
  logic [CW-1:0]                      w_fifo_count;
  logic [CW-1:0]                      w_count_next;
  logic [ENTRY_W-1:0]                 w_head;
  logic [VRAM_BANK_ADDRESS_WIDTH-1:0] w_bank_address;
  logic [31:0]                        w_write_data;
  logic                               w_even_we;
  logic                               w_odd_we;

  // Reads wait for an empty buffer so they always observe earlier writes.
  assign host_ready    = r_host_ready && (host_write || w_fifo_empty);
  assign w_accept      = host_valid && host_ready;
  assign w_push        = w_accept && host_write;
  assign w_read_accept = w_accept && !host_write;
  assign w_pop         = (r_state == ST_IDLE) && slot_available && !w_fifo_empty;
  assign w_count_next  = w_fifo_count + CW'(w_push) - CW'(w_pop);

  vram_write_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_push      (w_push),
    .i_push_data ({host_address, host_write_data}),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_count     (w_fifo_count),
    .o_empty     (w_fifo_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:         if (w_read_accept) w_state_next = ST_READ_WAIT;
      ST_READ_WAIT:    if (slot_available) w_state_next = ST_READ_CAPTURE;
      ST_READ_CAPTURE: w_state_next = ST_IDLE;
      default:         w_state_next = ST_IDLE;
    endcase
  end

  // Outside driven cycles the bank lines replay the last value, so they never toggle idle.
  always_comb begin
    w_bank_address = r_last_address;
    w_write_data   = r_last_wdata;
    w_even_we      = 1'b0;
    w_odd_we       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pop) begin
          w_bank_address = w_head[ENTRY_W-1:VRAM_WORD_WIDTH+1];
          w_write_data   = {w_head[VRAM_WORD_WIDTH-1:0], w_head[VRAM_WORD_WIDTH-1:0]};
          w_even_we      = !w_head[VRAM_WORD_WIDTH];
          w_odd_we       = w_head[VRAM_WORD_WIDTH];
        end
      end
      ST_READ_WAIT, ST_READ_CAPTURE: w_bank_address = r_rd_address;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_host_ready      <= 1'b1;
      r_rd_address      <= '0;
      r_rd_bank         <= 1'b0;
      r_host_read_data  <= '0;
      r_host_read_valid <= 1'b0;
      r_last_address    <= '0;
      r_last_wdata      <= '0;
    end else begin
      r_host_ready      <= (w_state_next == ST_IDLE) && (w_count_next != FULL_COUNT);
      r_host_read_valid <= (r_state == ST_READ_CAPTURE);
      r_last_address    <= w_bank_address;
      r_last_wdata      <= w_write_data;
      if (w_read_accept) begin
        r_rd_address <= host_address[ADDRESS_WIDTH-1:1];
        r_rd_bank    <= host_address[0];
      end
      if (r_state == ST_READ_CAPTURE)
        r_host_read_data <= r_rd_bank ? vram_read_data[31:16] : vram_read_data[15:0];
    end
  end

  assign vram_even_address  = w_bank_address;
  assign vram_odd_address   = w_bank_address;
  assign vram_even_write_en = w_even_we;
  assign vram_odd_write_en  = w_odd_we;
  assign vram_write_data    = w_write_data;
  assign host_read_data     = r_host_read_data;
  assign host_read_valid    = r_host_read_valid;
  assign busy               = !w_fifo_empty || (r_state != ST_IDLE);
endmodule

// File: tb/tb_vram_host_port.sv
// Directed bench for vram_host_port with a two-bank VRAM model and write/read scoreboards.
module tb_vram_host_port;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        host_valid = 1'b0;
  logic        host_write = 1'b0;
  logic [14:0] host_address = '0;
  logic [15:0] host_write_data = '0;
  logic        host_ready;
  logic [15:0] host_read_data;
  logic        host_read_valid;
  logic        slot_available;
  logic [13:0] vram_even_address;
  logic [13:0] vram_odd_address;
  logic        vram_even_write_en;
  logic        vram_odd_write_en;
  logic [31:0] vram_write_data;
  logic [31:0] vram_read_data = '0;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int slot_mode = 0;

  typedef struct packed {
    logic        bank;
    logic [13:0] addr;
    logic [15:0] data;
  } wexp_t;

  wexp_t       wq[$];
  logic [15:0] rq[$];
  wexp_t       mon_w;
  logic [15:0] mon_r;

  logic [15:0] mem_even [16384];
  logic [15:0] mem_odd  [16384];
  logic [15:0] ref_mem  [32768];

  vram_host_port dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .host_valid         (host_valid),
    .host_write         (host_write),
    .host_address       (host_address),
    .host_write_data    (host_write_data),
    .host_ready         (host_ready),
    .host_read_data     (host_read_data),
    .host_read_valid    (host_read_valid),
    .slot_available     (slot_available),
    .vram_even_address  (vram_even_address),
    .vram_odd_address   (vram_odd_address),
    .vram_even_write_en (vram_even_write_en),
    .vram_odd_write_en  (vram_odd_write_en),
    .vram_write_data    (vram_write_data),
    .vram_read_data     (vram_read_data),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  always begin
    @(posedge clk);
    #1 cyc = cyc + 1;
  end

  assign slot_available = (slot_mode == 1) || ((slot_mode == 2) && (cyc[1:0] == 2'b00));

  // Two-bank VRAM with one cycle of read latency.
  always @(posedge clk) begin
    if (vram_even_write_en) mem_even[vram_even_address] <= vram_write_data[15:0];
    if (vram_odd_write_en)  mem_odd[vram_odd_address]   <= vram_write_data[31:16];
    vram_read_data <= {mem_odd[vram_odd_address], mem_even[vram_even_address]};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void expect_write(input logic [14:0] a, input logic [15:0] d);
    wexp_t e;
    e = {a[0], a[14:1], d};
    wq.push_back(e);
    ref_mem[a] = d;
  endfunction

  always @(negedge clk) begin
    if (vram_even_write_en || vram_odd_write_en) begin
      check("wr_in_slot", 32'(slot_available), 1);
      check("wr_expected", 32'(wq.size() != 0), 1);
      if (wq.size() != 0) begin
        mon_w = wq.pop_front();
        check("wr_bank", 32'({vram_odd_write_en, vram_even_write_en}), 32'({mon_w.bank, !mon_w.bank}));
        check("wr_addr", 32'(mon_w.bank ? vram_odd_address : vram_even_address), 32'(mon_w.addr));
        check("wr_data", vram_write_data, {mon_w.data, mon_w.data});
      end
    end
    if (host_read_valid) begin
      check("rd_expected", 32'(rq.size() != 0), 1);
      if (rq.size() != 0) begin
        mon_r = rq.pop_front();
        check("rd_data", 32'(host_read_data), 32'(mon_r));
      end
    end
  end

  task automatic host_req(input logic wr, input logic [14:0] a, input logic [15:0] d);
    int n = 0;
    host_valid = 1'b1;
    host_write = wr;
    host_address = a;
    host_write_data = d;
    @(negedge clk);
    while (!host_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("accept", 32'(n < 100), 1);
    @(posedge clk);
    if (wr) expect_write(a, d);
    else    rq.push_back(ref_mem[a]);
    #1 host_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy || rq.size() != 0 || wq.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(n < 200), 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int slot_i;
    int valid_i;
    int pulses;
    int busy_low;
    for (int i = 0; i < 16384; i++) begin
      mem_even[i] = '0;
      mem_odd[i]  = '0;
    end
    for (int i = 0; i < 32768; i++) ref_mem[i] = '0;

    // Reset values, during and after reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(host_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_rvalid", 32'(host_read_valid), 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("rel_ready", 32'(host_ready), 1);
    check("rel_rdata", 32'(host_read_data), 0);
    check("rel_rvalid", 32'(host_read_valid), 0);
    check("rel_busy", 32'(busy), 0);
    check("rel_even_addr", 32'(vram_even_address), 0);
    check("rel_odd_addr", 32'(vram_odd_address), 0);
    check("rel_we", 32'({vram_odd_write_en, vram_even_write_en}), 0);
    check("rel_wdata", vram_write_data, 0);
    @(posedge clk);
    #1;

    // Single write with slot always granted
    slot_mode = 1;
    host_req(1'b1, 15'h0003, 16'hBEEF);
    @(negedge clk);
    check("t1_odd_we", 32'(vram_odd_write_en), 1);
    check("t1_even_we", 32'(vram_even_write_en), 0);
    check("t1_odd_addr", 32'(vram_odd_address), 32'h0001);
    check("t1_wdata_hi", 32'(vram_write_data[31:16]), 32'hBEEF);
    wait_idle();

    // Fill the buffer with no slots, then drain in consecutive cycles
    slot_mode = 0;
    for (int i = 0; i < 4; i++) host_req(1'b1, 15'(16'h0010 + i), 16'(16'hA000 + i));
    host_valid = 1'b1;
    host_write = 1'b1;
    host_address = 15'h0014;
    host_write_data = 16'hA004;
    @(negedge clk);
    check("t3_full_ready", 32'(host_ready), 0);
    check("t3_full_busy", 32'(busy), 1);
    @(posedge clk);
    #1 slot_mode = 1;
    @(negedge clk);
    check("t3_ready_first_pop", 32'(host_ready), 0);
    check("t3_we_0", 32'(vram_even_write_en | vram_odd_write_en), 1);
    @(negedge clk);
    check("t3_ready_after_pop", 32'(host_ready), 1);
    check("t3_we_1", 32'(vram_even_write_en | vram_odd_write_en), 1);
    @(posedge clk);
    expect_write(15'h0014, 16'hA004);
    #1 host_valid = 1'b0;
    for (int i = 2; i < 5; i++) begin
      @(negedge clk);
      check("t3_we_burst", 32'(vram_even_write_en | vram_odd_write_en), 1);
    end
    wait_idle();

    // Read after write stalls until the buffer drains
    host_req(1'b1, 15'h0002, 16'h1234);
    host_valid = 1'b1;
    host_write = 1'b0;
    host_address = 15'h0002;
    @(negedge clk);
    check("t4_read_stall", 32'(host_ready), 0);
    check("t4_even_first", 32'(vram_even_write_en), 1);
    host_req(1'b0, 15'h0002, 16'h0000);
    lat = 0;
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      @(negedge clk);
      if (host_read_valid) lat = i;
    end
    check("t4_latency", lat, 3);
    wait_idle();

    // Read from the top word with sparse slots
    host_req(1'b1, 15'h7FFF, 16'hC0DE);
    host_req(1'b1, 15'h7FFE, 16'h5555);
    wait_idle();
    slot_mode = 2;
    host_req(1'b0, 15'h7FFF, 16'h0000);
    slot_i = 0;
    valid_i = 0;
    pulses = 0;
    busy_low = 0;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      if (i == 1) begin
        check("t5_odd_addr", 32'(vram_odd_address), 32'h3FFF);
        check("t5_even_addr", 32'(vram_even_address), 32'h3FFF);
      end
      if (slot_i == 0 && slot_available) slot_i = i;
      if (host_read_valid) begin
        pulses++;
        if (valid_i == 0) valid_i = i;
      end
      if (valid_i == 0 && !busy) busy_low++;
    end
    check("t5_pulses", pulses, 1);
    check("t5_slot_to_valid", valid_i, slot_i + 2);
    check("t5_busy_held", busy_low, 0);
    wait_idle();

    // Reset in the middle of a drain discards the rest
    slot_mode = 0;
    host_req(1'b1, 15'h0100, 16'h1111);
    host_req(1'b1, 15'h0101, 16'h2222);
    host_req(1'b1, 15'h0102, 16'h3333);
    slot_mode = 1;
    @(negedge clk);
    check("t6_first_issue", 32'(vram_even_write_en), 1);
    @(posedge clk);
    #1 reset_n = 1'b0;
    wq.delete();
    ref_mem[15'h0101] = 16'h0000;
    ref_mem[15'h0102] = 16'h0000;
    @(negedge clk);
    check("t6_rst_we", 32'({vram_odd_write_en, vram_even_write_en}), 0);
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_ready", 32'(host_ready), 1);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("t6_rel_busy", 32'(busy), 0);
    check("t6_rel_we", 32'({vram_odd_write_en, vram_even_write_en}), 0);
    @(posedge clk);
    #1;
    host_req(1'b1, 15'h0105, 16'h7777);
    host_req(1'b0, 15'h0101, 16'h0000);
    host_req(1'b0, 15'h0102, 16'h0000);
    host_req(1'b0, 15'h0100, 16'h0000);
    host_req(1'b0, 15'h0105, 16'h0000);
    wait_idle();

    // Push and pop together at two entries across pointer wrap
    slot_mode = 0;
    host_req(1'b1, 15'h0200, 16'h4000);
    host_req(1'b1, 15'h0201, 16'h4001);
    slot_mode = 1;
    host_valid = 1'b1;
    host_write = 1'b1;
    for (int i = 0; i < 10; i++) begin
      host_address = 15'(16'h0202 + i);
      host_write_data = 16'(16'h4002 + i);
      @(negedge clk);
      check("t7_ready", 32'(host_ready), 1);
      check("t7_count", 32'(dut.w_fifo_count), 2);
      @(posedge clk);
      expect_write(15'(16'h0202 + i), 16'(16'h4002 + i));
      #1;
    end
    host_valid = 1'b0;
    wait_idle();
    host_req(1'b0, 15'h0200, 16'h0000);
    host_req(1'b0, 15'h0207, 16'h0000);
    host_req(1'b0, 15'h020B, 16'h0000);
    wait_idle();

    check("end_wq_empty", 32'(wq.size()), 0);
    check("end_rq_empty", 32'(rq.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/vram_host_port.md
Name: vram_host_port

Overview:
- Host-side initiator for the 64 KB VRAM, which is built as two independently addressed 16-bit banks (even and odd words, 14-bit bank address each, 1-cycle read latency).
- Accepts 16-bit word reads and writes from the CPU bus through a valid/ready handshake and buffers writes in a small FIFO.
- Drives the VRAM bank address, write-enable and data lines only in cycles granted by the external VRAM arbiter (slot_available).

Parameters:
- FIFO_DEPTH, 4, write-buffer entries; power of 2, minimum 2.
- ADDRESS_WIDTH, 15, host word-address width. Bit 0 selects the bank; bits [14:1] form the bank address.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- host_valid  input  1  request present
- host_write  input  1  1 = write, 0 = read; qualified by host_valid
- host_address  input  15  word address
- host_write_data  input  16  write data
- host_ready  output  1  request accepted on this edge when high together with host_valid
- host_read_data  output  16  read result
- host_read_valid  output  1  one-cycle pulse; host_read_data is valid
- slot_available  input  1  arbiter grants VRAM access this cycle
- vram_even_address  output  14  even-bank address
- vram_odd_address  output  14  odd-bank address
- vram_even_write_en  output  1  even-bank write strobe
- vram_odd_write_en  output  1  odd-bank write strobe
- vram_write_data  output  32  {odd, even} write data
- vram_read_data  input  32  {odd, even} bank read data, valid 1 cycle after address
- busy  output  1  writes buffered or a read outstanding

Behaviour:
- Clock and reset: single clock. Reset is asynchronous, active-low. Clock port is clk; reset port is reset_n.
- Reset values:
  - FIFO empty; state IDLE.
  - host_ready = 1, host_read_valid = 0, host_read_data = 0, busy = 0.
  - All vram_* outputs = 0.
  - Reset mid-operation discards buffered writes and any pending read; no partial VRAM write occurs after reset asserts.
- Handshake:
  - host_ready is registered. It is low while FIFO count == FIFO_DEPTH, and low while state != IDLE.
  - A read is accepted only when the FIFO is empty, which preserves write-before-read ordering.
  - If a read is presented while the FIFO is non-empty, host_ready for that read is 0 until the FIFO drains; writes remain acceptable meanwhile.
  - A transfer occurs when host_valid && host_ready at the clock edge.
- Write path:
  - An accepted write pushes {address, data} into the FIFO.
  - In a cycle with slot_available and FIFO non-empty (state IDLE), the head entry is presented:
    - both bank addresses = head address[14:1];
    - vram_write_data = {data, data};
    - only the bank selected by address[0] has its write_en = 1.
  - The head pops at that edge. Throughput is one write per granted slot.
  - A push and a pop in the same cycle leave the count unchanged.
  - The FIFO pointers wrap modulo FIFO_DEPTH.
- Read FSM: IDLE -> READ_WAIT -> READ_CAPTURE -> IDLE.
  - IDLE: an accepted read latches address and bank bit, then moves to READ_WAIT.
  - READ_WAIT: bank addresses are driven from the latched address, write enables stay 0. On slot_available, move to READ_CAPTURE.
  - READ_CAPTURE: sample the half of vram_read_data selected by the latched bank bit into host_read_data, pulse host_read_valid for one cycle, return to IDLE.
  - Latency: host_read_valid is high 2 cycles after the granted slot cycle. Minimum 3 cycles from acceptance.
- Output discipline:
  - Write enables are 0 in every cycle without slot_available.
  - Address outputs are don't-care outside the slot and read-capture cycles, but are held stable, with no toggling on idle.
- busy = (FIFO count != 0) || (state != IDLE).

Decomposition:
- Shared package vram_pkg:
  - VRAM_BANK_ADDRESS_WIDTH = 14;
  - VRAM_WORD_WIDTH = 16;
  - VRAM_READ_LATENCY = 1;
  - read FSM state enum.
- One sub-module: vram_write_fifo, a synchronous FIFO with count output, parameterised by depth and width (31 bits: address plus data).

Test Plan:
- Single write, slot always high: write addr 0x0003, data 0xBEEF -> next cycle vram_odd_write_en = 1, odd address 0x0001, vram_write_data[31:16] = 0xBEEF, even_write_en = 0.
- Fill FIFO with slot held low: 4 writes accepted, then host_ready = 0 on the 5th. Raise slot -> 4 writes issued in 4 consecutive cycles in FIFO order, host_ready returns to 1 after the first pop.
- Read after write: write 0x0002 = 0x1234, then read 0x0002 -> read stalls until the FIFO is empty, even bank written first. With the VRAM model returning 0x1234, host_read_data = 0x1234 with host_read_valid 2 cycles after the read slot.
- Read with sparse slots: slot high only every 4th cycle. Read 0x7FFF -> odd address 0x3FFF, upper half returned, a single host_read_valid pulse, busy high throughout.
- Reset mid-drain: 3 buffered writes, assert reset_n = 0 after the first issues -> no further write_en, busy = 0, FIFO empty. After release, a new write succeeds.
- Simultaneous push and pop with the FIFO at 2 entries and slot high -> count stays 2, and data order is preserved across pointer wrap over 10 writes.
